branch_cmp_pipe: RTL and testbench

Parametrised, registered branch-condition unit for the MIPS pipeline. Generalises the equality-only comparator to the full MIPS branch set plus signed and unsigned less-than. It registers the decision behind a one-entry valid/ready output stage with stall and flush support. It compares the decision against the fetch-stage prediction to flag mispredicts.

---
 rtl/branch_cmp_pipe.sv | 139 +++++++++++++
 tb/tb_branch_cmp_pipe.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/branch_cmp_pipe.sv
// branch_cmp_pipe: registered MIPS branch-condition unit.
// Evaluates EQ/NE/LEZ/GTZ/LTZ/GEZ/LT/LTU on (A1, A2). The decision sits in a
// one-entry valid/ready output stage that supports stall and flush. The
// registered decision is compared with the fetch-stage prediction to flag a
// mispredict.
// Optional feature: define BRCMP_PERF_EN to build the branch/taken/mispredict
// performance counters. Without it, the counter outputs read 0.

module branch_cmp_cond #(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] a2,
  output logic             cond
);

  localparam logic [2:0] OP_EQ  = 3'b000;
  localparam logic [2:0] OP_NE  = 3'b001;
  localparam logic [2:0] OP_LEZ = 3'b010;
  localparam logic [2:0] OP_GTZ = 3'b011;
  localparam logic [2:0] OP_LTZ = 3'b100;
  localparam logic [2:0] OP_GEZ = 3'b101;
  localparam logic [2:0] OP_LT  = 3'b110;
  localparam logic [2:0] OP_LTU = 3'b111;

  logic eq, sgn, zero, lt_s, lt_u;

  // Native compares only; subtract-and-test-sign would be wrong on overflow.
  assign eq   = (a1 == a2);
  assign sgn  = a1[WIDTH-1];
  assign zero = (a1 == '0);
  assign lt_s = ($signed(a1) < $signed(a2));
  assign lt_u = (a1 < a2);

  // Select the condition for the requested branch op.
  always_comb begin
    cond = 1'b0;
    unique case (op)
      OP_EQ:  cond = eq;
      OP_NE:  cond = !eq;
      OP_LEZ: cond = sgn | zero;
      OP_GTZ: cond = !sgn & !zero;
      OP_LTZ: cond = sgn;
      OP_GEZ: cond = !sgn;
      OP_LT:  cond = lt_s;
      OP_LTU: cond = lt_u;
      default: cond = 1'b0;
    endcase
  end

endmodule

module branch_cmp_pipe #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A1,
  input  logic [WIDTH-1:0] A2,
  input  logic             pred_taken,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             taken,
  output logic             mispredict,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t state, state_nxt;
  logic   cond, accept, xfer;

  branch_cmp_cond #(.WIDTH(WIDTH)) u_cond (
    .op   (op),
    .a1   (A1),
    .a2   (A2),
    .cond (cond)
  );

  assign out_valid = (state == FULL);
  // in_ready depends only on the output stage, never on in_valid/flush/operands.
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready && !flush;
  // A flush in the same cycle cancels the transfer.
  assign xfer      = out_valid && out_ready && !flush;

  // Output-stage occupancy register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= EMPTY;
    else       state <= state_nxt;
  end

  // Next occupancy: flush beats accept and hold; drain empties the stage.
  always_comb begin
    state_nxt = state;
    if (flush)       state_nxt = EMPTY;
    else if (accept) state_nxt = FULL;
    else if (xfer)   state_nxt = EMPTY;
  end

  // Decision register: loads on accept and keeps its value otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      taken      <= 1'b0;
      mispredict <= 1'b0;
    end else if (accept) begin
      taken      <= cond;
      mispredict <= cond ^ pred_taken;
    end
  end

`ifdef BRCMP_PERF_EN
  // Performance counters bump on each completed transfer and wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      br_cnt      <= '0;
      taken_cnt   <= '0;
      mispred_cnt <= '0;
    end else if (xfer) begin
      br_cnt      <= br_cnt + 1'b1;
      taken_cnt   <= taken_cnt + {{(CNT_W-1){1'b0}}, taken};
      mispred_cnt <= mispred_cnt + {{(CNT_W-1){1'b0}}, mispredict};
    end
  end
`else
  assign br_cnt      = '0;
  assign taken_cnt   = '0;
  assign mispred_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_cmp_pipe.sv
// Self-checking bench for branch_cmp_pipe: directed corner cases plus random
// traffic, checked every cycle against a transaction-level model.
module tb_branch_cmp_pipe;

  localparam int W  = 32;
  localparam int CW = 4;

  logic          clk = 0, reset = 1;
  logic          in_valid = 0, in_ready, pred_taken = 0, flush = 0;
  logic          out_valid, out_ready = 0, taken, mispredict;
  logic [2:0]    op = 0;
  logic [W-1:0]  A1 = 0, A2 = 0;
  logic [CW-1:0] br_cnt, taken_cnt, mispred_cnt;

  int checks = 0, errors = 0;

  branch_cmp_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .A1(A1), .A2(A2), .pred_taken(pred_taken), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .taken(taken),
    .mispredict(mispredict), .br_cnt(br_cnt), .taken_cnt(taken_cnt),
    .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Branch condition straight from the ISA definitions, using signed integers.
  function automatic bit ref_cond(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    ua = longint'(a);
    ub = longint'(b);
    sa = a[31] ? ua - 64'sd4294967296 : ua;
    sb = b[31] ? ub - 64'sd4294967296 : ub;
    case (o)
      3'd0: return sa == sb;
      3'd1: return sa != sb;
      3'd2: return sa <= 0;
      3'd3: return sa > 0;
      3'd4: return sa < 0;
      3'd5: return sa >= 0;
      3'd6: return sa < sb;
      default: return ua < ub;
    endcase
  endfunction

  // Model: one held result plus transfer counts.
  bit m_valid, m_taken, m_mis;
  int m_br, m_tk, m_mp;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid = 0; m_taken = 0; m_mis = 0; m_br = 0; m_tk = 0; m_mp = 0;
    end else begin
      bit can_take, done;
      can_take = !m_valid || out_ready;
      done     = m_valid && out_ready && !flush;
      if (done) begin
        m_br = (m_br + 1) % (1 << CW);
        m_tk = (m_tk + int'(m_taken)) % (1 << CW);
        m_mp = (m_mp + int'(m_mis)) % (1 << CW);
      end
      if (flush) m_valid = 0;
      else if (in_valid && can_take) begin
        m_valid = 1;
        m_taken = ref_cond(op, A1, A2);
        m_mis   = m_taken ^ pred_taken;
      end else if (done) m_valid = 0;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (!reset) begin
      chk("in_ready", in_ready, !m_valid || out_ready);
      chk("out_valid", out_valid, m_valid);
      if (m_valid) begin
        chk("taken", taken, m_taken);
        chk("mispredict", mispredict, m_mis);
      end
`ifdef BRCMP_PERF_EN
      chk("br_cnt", br_cnt, m_br);
      chk("taken_cnt", taken_cnt, m_tk);
      chk("mispred_cnt", mispred_cnt, m_mp);
`else
      chk("br_cnt0", br_cnt, 0);
      chk("taken_cnt0", taken_cnt, 0);
      chk("mispred_cnt0", mispred_cnt, 0);
`endif
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive(input bit iv, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input bit pt, input bit fl, input bit rdy);
    in_valid = iv; op = o; A1 = a; A2 = b; pred_taken = pt; flush = fl; out_ready = rdy;
  endtask

  // Accept one branch, return its registered decision, then drain it.
  task automatic one(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, output bit t);
    drive(1, o, a, b, 0, 0, 1); step();
    t = taken;
    drive(0, 0, 0, 0, 0, 0, 1); step();
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'h8000_0000;
      3: return 32'h7fff_ffff;
      4: return 32'hffff_ffff;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bit t;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_taken", taken, 0);
    chk("rst_mispredict", mispredict, 0);
    chk("rst_br_cnt", br_cnt, 0);
    step(); reset = 0;

    // Basic EQ with wrong prediction.
    drive(1, 3'd0, 32'h1234, 32'h1234, 0, 0, 1); step();
    chk("eq_valid", out_valid, 1);
    chk("eq_taken", taken, 1);
    chk("eq_mispred", mispredict, 1);
    drive(0, 0, 0, 0, 0, 0, 1); step();
    chk("drain_valid", out_valid, 0);

    // Sign / width boundaries.
    one(3'd6, 32'h8000_0000, 32'h1, t); chk("lt_signed", t, 1);
    one(3'd7, 32'h8000_0000, 32'h1, t); chk("ltu", t, 0);
    one(3'd4, 32'h8000_0000, 32'h1, t); chk("ltz", t, 1);
    one(3'd2, 32'h0, 32'h1, t);         chk("lez_zero", t, 1);
    one(3'd3, 32'h0, 32'h1, t);         chk("gtz_zero", t, 0);
    one(3'd5, 32'h0, 32'h1, t);         chk("gez_zero", t, 1);

    // Backpressure: hold three cycles with a different op waiting.
    drive(1, 3'd0, 32'h5, 32'h5, 1, 0, 0); step();
    chk("bp_first", taken, 1);
    drive(1, 3'd1, 32'h5, 32'h5, 1, 0, 0);
    repeat (3) begin
      step();
      chk("bp_in_ready", in_ready, 0);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_taken", taken, 1);
      chk("bp_hold_mis", mispredict, 0);
    end
    out_ready = 1; #1;
    chk("bp_ready_comb", in_ready, 1);
    step();
    chk("bp_second_valid", out_valid, 1);
    chk("bp_second_taken", taken, 0);
    drive(0, 0, 0, 0, 0, 0, 1); step();

    // Flush while holding, then flush while the consumer is ready.
    drive(1, 3'd0, 32'h1, 32'h1, 0, 0, 0); step();
    drive(1, 3'd0, 32'h1, 32'h1, 0, 1, 0); step();
    chk("flush_hold", out_valid, 0);
    drive(1, 3'd0, 32'h1, 32'h1, 0, 0, 0); step();
    drive(1, 3'd0, 32'h1, 32'h1, 0, 1, 1); step();
    chk("flush_ready", out_valid, 0);
    drive(0, 0, 0, 0, 0, 0, 1); step();

    // Back-to-back EQ/NE on equal operands.
    for (int i = 0; i < 4; i++) begin
      drive(1, (i % 2 == 0) ? 3'd0 : 3'd1, 32'hA5, 32'hA5, 0, 0, 1); step();
      chk("b2b_valid", out_valid, 1);
      chk("b2b_taken", taken, (i % 2 == 0) ? 1 : 0);
    end
    drive(0, 0, 0, 0, 0, 0, 1); step();

    // Reset in the middle of a hold; first accept after release.
    drive(1, 3'd0, 32'h2, 32'h2, 0, 0, 0); step();
    #2 reset = 1; #1;
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_taken", taken, 0);
    drive(1, 3'd0, 32'h3, 32'h3, 0, 0, 1);
    step();
    chk("rst_held_valid", out_valid, 0);
    reset = 0;
    step();
    chk("post_rst_accept", out_valid, 1);

    // Counter wrap: 17 taken, mispredicted transfers from a clean reset.
    reset = 1; drive(0, 0, 0, 0, 0, 0, 1); step(); reset = 0;
    repeat (17) begin drive(1, 3'd0, 32'h9, 32'h9, 0, 0, 1); step(); end
    drive(0, 0, 0, 0, 0, 0, 1); step();
`ifdef BRCMP_PERF_EN
    chk("wrap_br", br_cnt, 1);
    chk("wrap_tk", taken_cnt, 1);
    chk("wrap_mp", mispred_cnt, 1);
`else
    chk("off_br", br_cnt, 0);
    chk("off_tk", taken_cnt, 0);
    chk("off_mp", mispred_cnt, 0);
`endif

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] a, b;
      a = pick();
      b = ($urandom_range(0, 3) == 0) ? a : pick();
      drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), a, b,
            $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0,
            $urandom_range(0, 9) < 7);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
